// File: rtl/stn_pixel_packer.sv
// Packs grey-scaled STN pixels (1 or 3 bits each) LSB-first into 8-bit panel words behind a small FIFO.
// Optional macro PACKER_FRAME_WORDS_EN builds the per-frame pushed-word counter.
module stn_pixel_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  greypixel,
    input  logic        valid,
    output logic        stall,
    input  logic        frame_end,
    input  logic        mono,
    output logic [7:0]  panel_data,
    output logic        panel_valid,
    input  logic        panel_ready,
    output logic [15:0] frame_words
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] STALL_LVL = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_ACC   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic           init_q, init_d;
    logic           mono_q, mono_d;
    logic [9:0]     acc_q, acc_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;

    logic           accept_s;
    logic [9:0]     in_bits_s;
    logic [3:0]     in_cnt_s;
    logic [9:0]     merged_s;
    logic [3:0]     sum_s;
    logic           push_s;
    logic [7:0]     push_data_s;
    logic           pop_s;
    logic           leave_flush_s;

    // Stall depends only on registered state so upstream sees a clean hold request.
    assign stall       = (state_q == ST_FLUSH) | (count_q >= STALL_LVL);
    assign panel_valid = (count_q != (AW+1)'(0));
    assign panel_data  = panel_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign pop_s       = panel_valid & panel_ready;

    // Incoming pixel bits merged above the pending bits.
    always_comb begin
        accept_s = valid & ~stall;
        if (mono_q) begin
            in_bits_s = {9'b0, greypixel[0]};
            in_cnt_s  = 4'd1;
        end else begin
            in_bits_s = {7'b0, greypixel};
            in_cnt_s  = 4'd3;
        end
        merged_s = acc_q | (in_bits_s << cnt_q);
        sum_s    = cnt_q + in_cnt_s;
    end

    // Packing FSM: next state, accumulator update and FIFO push request.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        init_d        = 1'b0;
        push_s        = 1'b0;
        push_data_s   = 8'h00;
        leave_flush_s = 1'b0;
        if (init_q) begin
            mono_d = mono;
        end else begin
            mono_d = mono_q;
        end
        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
                    if (sum_s >= 4'd8) begin
                        push_s      = 1'b1;
                        push_data_s = merged_s[7:0];
                        acc_d       = {8'b0, merged_s[9:8]};
                        cnt_d       = sum_s - 4'd8;
                    end else begin
                        acc_d = merged_s;
                        cnt_d = sum_s;
                    end
                end else begin
                    acc_d = acc_q;
                end
                if (frame_end) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_FLUSH: begin
                // Pending bits are kept zero above cnt_q, so the padded word is just acc_q.
                if (cnt_q == 4'd0) begin
                    leave_flush_s = 1'b1;
                end else if (count_q != FULL_LVL) begin
                    push_s        = 1'b1;
                    push_data_s   = acc_q[7:0];
                    acc_d         = 10'd0;
                    cnt_d         = 4'd0;
                    leave_flush_s = 1'b1;
                end else begin
                    leave_flush_s = 1'b0;
                end
                if (leave_flush_s) begin
                    state_d = ST_ACC;
                    mono_d  = mono;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // Word FIFO bookkeeping; simultaneous push and pop leave occupancy unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data_s;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State, accumulator and FIFO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ACC;
            init_q   <= 1'b1;
            mono_q   <= 1'b0;
            acc_q    <= 10'd0;
            cnt_q    <= 4'd0;
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            mono_q   <= mono_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef PACKER_FRAME_WORDS_EN
    logic [15:0] fw_q, fw_d;

    // Saturating per-frame push counter, cleared when a flush completes.
    always_comb begin
        if (leave_flush_s) begin
            fw_d = 16'h0000;
        end else if (push_s && (fw_q != 16'hFFFF)) begin
            fw_d = fw_q + 16'd1;
        end else begin
            fw_d = fw_q;
        end
    end

    // Frame word counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fw_q <= 16'h0000;
        end else begin
            fw_q <= fw_d;
        end
    end

    assign frame_words = fw_q;
`else
    assign frame_words = 16'h0000;
`endif

endmodule
